param_array_serializer: RTL and testbench
=========================================

# param_array_serializer

Consumer end of the parameterized unpacked-array port interface. It accepts a whole unpacked array of `TEST` lanes in one valid/ready handshake and emits the lanes one per beat on a narrow valid/ready stream, lane 0 first. It sits downstream of blocks that drive `[TEST+2-1:0] name [TEST]` style outputs and feeds serial links and FIFOs.

## Interface
- `TEST`, 6, lane count N of the input array; lane width is `TEST+2` bits (W); must be ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input array offered.
- `in_ready`  out  1  block can accept an array this cycle.
- `in_array`  in  W, unpacked [TEST]  lanes to serialize.
- `in_count`  in  $clog2(TEST+1)  number of lanes to send, starting at lane 0 (0..TEST).
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts beat.
- `out_data`  out  W  current lane.
- `out_index`  out  $clog2(TEST)  lane number of current beat.
- `out_last`  out  1  final beat of the frame.

## Operation
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0; state IDLE.
- States:
  - IDLE: `in_ready`=1. On `in_valid&&in_ready` with effective count C>0: register all lanes and C, idx=0, go to SEND. With C=0: accept, drop the frame, stay in IDLE, no output beat.
  - SEND: `out_valid`=1, `out_data`=lane[idx], `out_index`=idx, `out_last`=(idx==C-1). On `out_valid&&out_ready`: if not last, idx+=1; if last, go to IDLE, or reload directly if a new array is accepted in the same cycle.
- `in_ready` in SEND equals `out_ready && out_last`. This gives zero-bubble back-to-back frames. On that simultaneous event the new frame's lane 0 is presented on the next cycle.
- Effective count C = min(`in_count`, TEST). Values above TEST are clamped, never wrapped.
- Lanes are captured in full at acceptance. Later changes on `in_array` have no effect on the frame in flight.
- `out_data`, `out_index` and `out_last` hold stable while `out_valid && !out_ready`.
- Deasserting `rst_n` mid-frame: all outputs return to reset values asynchronously and the partial frame is discarded; no partial frame resumes after release.

## Timing
- Latency: array accepted at edge k; lane 0 is valid after edge k, in cycle k+1.
- Throughput: one beat per cycle with `out_ready` held high. A frame of C lanes occupies C cycles.
- Outputs are registered; there is no combinational path from `in_*` to `out_*`.
- Exception: `in_ready` depends combinationally on `out_ready` in SEND.

## Configuration
- `PARAM_ARRAY_SER_PARITY_EN` defined:
  - Adds port `out_parity`  out  1, the even parity (XOR-reduce) of `out_data`, registered alongside it.
  - Reset value is 0.
  - Held stable under backpressure.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `param_array_pkg`:
  - default `TEST` constant;
  - `lane_t` typedef (`logic [TEST+2-1:0]`);
  - state enum {IDLE, SEND};
  - count/index width localparams.
- No sub-module: the lane-select mux and index counter are small enough to be inline.

## Test plan
- Reset mid-frame (TEST=6, C=6, reset asserted after beat 2, then a new frame of lanes 0x40..0x45) -> outputs zero immediately; after release, output starts at lane 0 of the new frame, and no 0x13.. beats appear.
- TEST=6, lanes 0x10..0x15, C=6, `out_ready`=1 -> six beats 0x10..0x15 in consecutive cycles, `out_index` 0..5, `out_last` only on 0x15.
- Back-to-back: frame A (C=3) then frame B (C=2) held valid -> beats A0 A1 A2 B0 B1 with no idle cycle; `in_ready` high exactly on the A2 handshake.
- Backpressure: `out_ready` toggled 1,0,0,1 during beat 1 -> beat 1 data/index/last stable through the stall; no lane skipped or duplicated.
- Boundaries: C=0 -> accepted in one cycle with no beat. C=1 -> single beat with `out_last`=1. `in_count`=7 with TEST=6 -> six beats, clamped. With the parity macro, lane 0x07 -> `out_parity`=1.

Source files
------------

// File: rtl/param_array_pkg.sv
// ============================================================================
//  Module      : param_array_pkg
//  Description : Shared constants, lane type and FSM state encoding for the
//                parameterized unpacked-array serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package param_array_pkg;

    // Default lane count of the input array
    localparam int TEST_DEFAULT = 6;

    // Lane type for the default configuration (lane width is lane count + 2)
    typedef logic [TEST_DEFAULT+2-1:0] lane_t;

    // Serializer states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Width of a lane count 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of a lane index 0..n-1
    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    localparam int CNT_W_DEFAULT = $clog2(TEST_DEFAULT + 1);
    localparam int IDX_W_DEFAULT = $clog2(TEST_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/param_array_serializer_if.sv
// ============================================================================
//  Module      : param_array_serializer_if
//  Description : Array-in / lane-out handshake bundle. The master modport is
//                the upstream producer plus downstream sink; the slave
//                modport is the serializer itself.
//                Optional macro: PARAM_ARRAY_SER_PARITY_EN adds out_parity.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_array_serializer_if
    import param_array_pkg::*;
#(
    parameter int TEST = TEST_DEFAULT
) ();

    logic                         in_valid;
    logic                         in_ready;
    logic [TEST+2-1:0]            in_array [TEST];
    logic [cnt_width(TEST)-1:0]   in_count;

    logic                         out_valid;
    logic                         out_ready;
    logic [TEST+2-1:0]            out_data;
    logic [idx_width(TEST)-1:0]   out_index;
    logic                         out_last;
`ifdef PARAM_ARRAY_SER_PARITY_EN
    logic                         out_parity;
`endif

    modport master (
        output in_valid, in_array, in_count, out_ready,
`ifdef PARAM_ARRAY_SER_PARITY_EN
        input  out_parity,
`endif
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_array, in_count, out_ready,
`ifdef PARAM_ARRAY_SER_PARITY_EN
        output out_parity,
`endif
        output in_ready, out_valid, out_data, out_index, out_last
    );

endinterface

`default_nettype wire

// File: rtl/param_array_serializer.sv
// ============================================================================
//  Module      : param_array_serializer
//  Description : Accepts a whole unpacked array of TEST lanes in one
//                handshake and emits lanes 0..C-1 one per beat, where
//                C = min(in_count, TEST). All out_* signals are registered;
//                only in_ready looks combinationally at out_ready so a new
//                frame can be taken on the last beat of the current one.
//                Optional macro: PARAM_ARRAY_SER_PARITY_EN adds a registered
//                even-parity bit alongside out_data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_array_serializer
    import param_array_pkg::*;
#(
    parameter int TEST = TEST_DEFAULT
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    param_array_serializer_if.slave    bus
);

    localparam int W     = TEST + 2;
    localparam int CNT_W = cnt_width(TEST);
    localparam int IDX_W = idx_width(TEST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TEST);

    state_t             state_q, state_d;
    logic [W-1:0]       lanes_q [TEST];
    logic [W-1:0]       lanes_d [TEST];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       data_q, data_d;
    logic               last_q, last_d;

    logic [CNT_W-1:0]   w_eff_cnt;
    logic               w_in_ready;
    logic               w_load;
    logic [IDX_W-1:0]   w_next_idx;

    // Clamp the requested count (never wrap), and decide whether a frame is taken
    always_comb begin
        w_eff_cnt  = (bus.in_count > CNT_MAX) ? CNT_MAX : bus.in_count;
        w_in_ready = (state_q == IDLE) || (bus.out_ready && last_q);
        // A zero-length frame is still accepted, it simply loads nothing
        w_load     = bus.in_valid && w_in_ready && (w_eff_cnt != '0);
        w_next_idx = idx_q + IDX_W'(1);
    end

    // Next-state logic: load a new frame, advance one lane, or drop back to IDLE
    always_comb begin
        state_d = state_q;
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        if (w_load) begin
            state_d = SEND;
            lanes_d = bus.in_array;
            cnt_d   = w_eff_cnt;
            idx_d   = '0;
            data_d  = bus.in_array[0];
            last_d  = (w_eff_cnt == CNT_W'(1));
        end else if ((state_q == SEND) && bus.out_ready) begin
            if (last_q) begin
                state_d = IDLE;
                idx_d   = '0;
                data_d  = '0;
                last_d  = 1'b0;
            end else begin
                idx_d   = w_next_idx;
                data_d  = lanes_q[w_next_idx];
                last_d  = ((CNT_W'(w_next_idx) + CNT_W'(1)) == cnt_q);
            end
        end
    end

    // State, captured lanes and registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lanes_q <= '{default: '0};
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

`ifdef PARAM_ARRAY_SER_PARITY_EN
    logic parity_q;

    // Parity is registered from the same next value as out_data so they stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_d;
        end
    end

    assign bus.out_parity = parity_q;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = data_q;
    assign bus.out_index = idx_q;
    assign bus.out_last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_param_array_serializer.sv
// ============================================================================
//  Module      : tb_param_array_serializer
//  Description : Self-checking bench for param_array_serializer. A queue of
//                expected beats is filled whenever an array is accepted and
//                drained on every output handshake.
//                Optional macro: PARAM_ARRAY_SER_PARITY_EN checks out_parity.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_array_serializer;

    localparam int TEST = 6;
    localparam int W    = TEST + 2;
    localparam int CW   = $clog2(TEST + 1);

    typedef struct {
        logic [W-1:0] d;
        int           idx;
        bit           last;
    } beat_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    tests_run    = 0;
    int    tests_failed = 0;
    beat_t exp_q [$];
    int    mon_c;

    always #5 clk = ~clk;

    param_array_serializer_if #(.TEST(TEST)) bus ();

    param_array_serializer #(.TEST(TEST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one frame of min(count,TEST) lanes per accepted array
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", bus.out_valid, (exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("out_data",  bus.out_data,  exp_q[0].d);
                check("out_index", bus.out_index, exp_q[0].idx);
                check("out_last",  bus.out_last,  exp_q[0].last);
`ifdef PARAM_ARRAY_SER_PARITY_EN
                check("out_parity", bus.out_parity, ^exp_q[0].d);
`endif
            end
            check("in_ready", bus.in_ready,
                  (exp_q.size() == 0) || (bus.out_ready && exp_q.size() == 1));
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (bus.in_valid && bus.in_ready) begin
                mon_c = (int'(bus.in_count) > TEST) ? TEST : int'(bus.in_count);
                for (int i = 0; i < mon_c; i++)
                    exp_q.push_back('{d: bus.in_array[i], idx: i, last: (i == mon_c - 1)});
            end
        end
    end

    // Offer one array with lanes base+i until it is accepted
    task automatic send_frame(input logic [W-1:0] base, input int cnt);
        bit acc = 0;
        int n   = 0;
        bus.in_valid = 1'b1;
        bus.in_count = CW'(cnt);
        for (int i = 0; i < TEST; i++) bus.in_array[i] = base + W'(i);
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", acc, 1);
        bus.in_valid = 1'b0;
        // Scramble the inputs so a design that reads them late would be caught
        for (int i = 0; i < TEST; i++) bus.in_array[i] = W'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"},  bus.out_data,  0);
        check({tag, "_out_index"}, bus.out_index, 0);
        check({tag, "_out_last"},  bus.out_last,  0);
        check({tag, "_in_ready"},  bus.in_ready,  1);
`ifdef PARAM_ARRAY_SER_PARITY_EN
        check({tag, "_out_parity"}, bus.out_parity, 0);
`endif
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_count  = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < TEST; i++) bus.in_array[i] = '0;

        #12;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full frame, no backpressure
        send_frame(8'h10, 6);
        wait_idle();

        // Back-to-back frames with no idle cycle
        send_frame(8'h20, 3);
        send_frame(8'h30, 2);
        wait_idle();

        // Boundaries: empty frame, single lane (parity 1), clamped count
        send_frame(8'h50, 0);
        wait_idle();
        send_frame(8'h07, 1);
        wait_idle();
        send_frame(8'h60, 7);
        wait_idle();

        // Stall on beat 1
        send_frame(8'h70, 3);
        @(posedge clk); #1 bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a frame, then a fresh frame
        send_frame(8'h10, 6);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(8'h40, 6);
        wait_idle();

        // Randomized traffic
        repeat (3000) begin
            @(posedge clk);
            #1;
            bus.in_valid  = ($urandom_range(0, 2) == 0);
            bus.in_count  = CW'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < TEST; i++) bus.in_array[i] = W'($urandom);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
